// File: rtl/rapcore_seq_pkg.sv
// Shared definitions for the rapcore move sequencer: register map, bit indices,
// FSM state encoding and FIFO entry sizing.
package rapcore_seq_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned STEPS_W_DEF    = 32;
  localparam int unsigned PER_W_DEF      = 16;

  // Word offsets as decoded from wbs_adr_i[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_STEPS    = 3'd2;
  localparam logic [2:0] REG_PERIOD   = 3'd3;
  localparam logic [2:0] REG_DONE_CNT = 3'd4;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_DIR_INV = 2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_LEVEL_LSB = 4;
  localparam int unsigned STAT_HALTED    = 8;
  localparam int unsigned STAT_OVERFLOW  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_DONE
  } seq_state_e;

  // Entry layout is {dir, half_period, steps}
  function automatic int unsigned entry_w(input int unsigned per_w, input int unsigned steps_w);
    return 1 + per_w + steps_w;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous move-queue FIFO with flush; simultaneous push/pop is accepted when full.
module move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 49
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    count_q;
  logic             full_c, empty_c, do_push_c, do_pop_c;

  assign full_c    = (count_q == LW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign do_pop_c  = pop_i && !empty_c;
  assign do_push_c = push_i && (!full_c || do_pop_c);
  assign data_o    = mem_q[rptr_q];
  assign level_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push_c && !flush_i) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) wptr_q <= wptr_q + AW'(1);
      if (do_pop_c)  rptr_q <= rptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Wishbone-programmed step/direction sequencer: firmware queues moves, the FSM
// plays them out as STEP pulse trains with DIR set up a cycle ahead.
module move_sequencer
  import rapcore_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned STEPS_W    = STEPS_W_DEF,
  parameter int unsigned PER_W      = PER_W_DEF
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        halt_i,
  output logic        step_o,
  output logic        dir_o,
  output logic        move_done_o,
  output logic        buffer_dtr_o
);

  localparam int unsigned ENTRY_W = entry_w(PER_W, STEPS_W);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               enable_q, dir_inv_q, overflow_q, dtr_q;
  logic [STEPS_W-1:0] steps_q, done_cnt_q;
  logic               halt_s1_q, halted_q;
  logic               step_q, dir_q, done_q;
  seq_state_e         state_q;
  logic [ENTRY_W-1:0] mv_q;
  logic [PER_W-1:0]   timer_q;

  logic               accept_c, wr_c, abort_c, push_c, pop_c, full_c, empty_c;
  logic [2:0]         reg_sel_c;
  logic [31:0]        rdata_c;
  logic [ENTRY_W-1:0] fifo_wdata_c, fifo_rdata_c;
  logic [LVL_W-1:0]   level_c;
  logic               mv_dir_c;
  logic [PER_W-1:0]   mv_per_c, hp_last_c;
  logic [STEPS_W-1:0] mv_steps_c, done_next_c;
  logic               unused_adr_c;

  assign unused_adr_c = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign reg_sel_c    = wbs_adr_i[4:2];
  assign accept_c     = wbs_stb_i && wbs_cyc_i && !ack_q;
  assign wr_c         = accept_c && wbs_we_i && (wbs_sel_i == 4'hF);
  assign abort_c      = wr_c && (reg_sel_c == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
  assign push_c       = wr_c && (reg_sel_c == REG_PERIOD);
  assign full_c       = (level_c == LVL_W'(FIFO_DEPTH));
  assign empty_c      = (level_c == '0);
  assign pop_c        = (state_q == S_IDLE) && enable_q && !empty_c && !halted_q && !abort_c;
  assign fifo_wdata_c = {wbs_dat_i[31], wbs_dat_i[PER_W-1:0], steps_q};

  assign mv_dir_c    = mv_q[ENTRY_W-1];
  assign mv_per_c    = mv_q[STEPS_W +: PER_W];
  assign mv_steps_c  = mv_q[STEPS_W-1:0];
  // A zero half-period behaves as one cycle
  assign hp_last_c   = (mv_per_c == '0) ? '0 : mv_per_c - PER_W'(1);
  assign done_next_c = done_cnt_q + STEPS_W'(1);

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n   (rst_n),
    .flush_i (abort_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (fifo_wdata_c),
    .data_o  (fifo_rdata_c),
    .level_o (level_c)
  );

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      REG_CTRL: begin
        rdata_c[CTRL_ENABLE]  = enable_q;
        rdata_c[CTRL_DIR_INV] = dir_inv_q;
      end
      REG_STATUS: begin
        rdata_c[STAT_BUSY]             = (state_q != S_IDLE);
        rdata_c[STAT_FULL]             = full_c;
        rdata_c[STAT_EMPTY]            = empty_c;
        rdata_c[STAT_LEVEL_LSB +: 4]   = 4'(level_c);
        rdata_c[STAT_HALTED]           = halted_q;
        rdata_c[STAT_OVERFLOW]         = overflow_q;
      end
      REG_STEPS:    rdata_c = 32'(steps_q);
      REG_DONE_CNT: rdata_c = 32'(done_cnt_q);
      default:      rdata_c = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      enable_q   <= 1'b0;
      dir_inv_q  <= 1'b0;
      steps_q    <= '0;
      overflow_q <= 1'b0;
      dtr_q      <= 1'b1;
      halt_s1_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ack_q     <= accept_c;
      dat_q     <= (accept_c && !wbs_we_i) ? rdata_c : '0;
      dtr_q     <= !full_c;
      halt_s1_q <= halt_i;
      halted_q  <= halt_s1_q;
      if (wr_c && (reg_sel_c == REG_CTRL)) begin
        enable_q  <= wbs_dat_i[CTRL_ENABLE];
        dir_inv_q <= wbs_dat_i[CTRL_DIR_INV];
      end
      if (wr_c && (reg_sel_c == REG_STEPS)) steps_q <= STEPS_W'(wbs_dat_i);
      // A dropped push wins over a same-cycle clear
      if (push_c && full_c && !pop_c)
        overflow_q <= 1'b1;
      else if (wr_c && (reg_sel_c == REG_STATUS) && wbs_dat_i[STAT_OVERFLOW])
        overflow_q <= 1'b0;
    end
  end

  // Sequencer FSM; step/done outputs trail the state by one cycle and are
  // gated so abort and halt pull them low without waiting for the state.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mv_q       <= '0;
      timer_q    <= '0;
      done_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_q <= (state_q == S_HIGH) && !halted_q && !abort_c;
      done_q <= (state_q == S_DONE) && !halted_q && !abort_c;
      if (abort_c || halted_q) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pop_c) begin
              mv_q    <= fifo_rdata_c;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            dir_q      <= mv_dir_c ^ dir_inv_q;
            done_cnt_q <= '0;
            timer_q    <= '0;
            state_q    <= (mv_steps_c == '0) ? S_DONE : S_HIGH;
          end
          S_HIGH: begin
            if (timer_q == hp_last_c) begin
              timer_q <= '0;
              state_q <= S_LOW;
            end else begin
              timer_q <= timer_q + PER_W'(1);
            end
          end
          S_LOW: begin
            if (timer_q == hp_last_c) begin
              timer_q    <= '0;
              done_cnt_q <= done_next_c;
              state_q    <= (done_next_c == mv_steps_c) ? S_DONE : S_HIGH;
            end else begin
              timer_q <= timer_q + PER_W'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign step_o       = step_q;
  assign dir_o        = dir_q;
  assign move_done_o  = done_q;
  assign buffer_dtr_o = dtr_q;

endmodule
